adsr_envelope_gen: RTL and testbench
====================================

Name: adsr_envelope_gen

Overview:
- Parametrised successor to the fixed-shape note dynamics stage. Applies a linear ADSR gain envelope to a signed PCM stream.
- Gain, sample and duration widths are parametrised, and sustain level is programmable.
- Supports retrigger (legato) and an explicit note_off, plus an optional duration-timed auto-release.
- Sits between the note/waveform generator and the codec/mixer output. Envelope advances on the minibeat tick (192/s).

Parameters:
- SAMPLE_W, 16, signed sample width.
- GAIN_W, 8, unsigned envelope gain width; GAIN_MAX = 2^GAIN_W-1.
- DUR_W, 6, note duration width, in beats.
- CNT_W, 10, minibeat counter width; must hold (2^DUR_W-1)*4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- play_enable  in  1  low freezes envelope state, gain, counter and output.
- toggle_dynamics  in  1  1 = envelope applied, 0 = bypass.
- minibeat  in  1  single-cycle envelope tick.
- note_on  in  1  single-cycle start/retrigger pulse.
- note_off  in  1  single-cycle release pulse.
- duration  in  DUR_W  note length in beats; 0 = gate mode (note_off only).
- attack_step  in  GAIN_W  gain increment per tick; 0 = instantaneous.
- decay_step  in  GAIN_W  gain decrement per tick; 0 = instantaneous.
- sustain_level  in  GAIN_W  sustain gain.
- release_step  in  GAIN_W  gain decrement per tick; 0 = instantaneous.
- sample_ready  in  1  sample_in valid strobe.
- sample_in  in  SAMPLE_W  signed input sample.
- sample_out_ready  out  1  sample_out valid strobe.
- sample_out  out  SAMPLE_W  signed output sample.
- env_gain  out  GAIN_W  current gain.
- env_state  out  3  current FSM state.
- busy  out  1  high whenever env_state != IDLE.

Behaviour:
- Reset (synchronous, active-high) clears: state=IDLE, gain=0, minibeat counter=0, sample_out=0, sample_out_ready=0, busy=0. Reset takes priority over every other input, including in mid-note.
- Definition: adv = minibeat && play_enable. The FSM updates on adv; note_on and note_off are also accepted only while play_enable=1. All envelope inputs are sampled live and are not latched.
- States: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4. Other encodings go to IDLE on the next cycle.
- note_on (any state) → ATTACK next cycle. Gain is kept (no click on retrigger) and the counter is cleared. note_on takes priority over note_off and over auto-release in the same cycle.
- note_off in ATTACK, DECAY or SUSTAIN → RELEASE. In IDLE or RELEASE it is ignored.
- Auto-release: when duration!=0 and the counter reaches duration*4 in any of ATTACK, DECAY or SUSTAIN → RELEASE.
- Counter: increments on adv while busy and saturates at its maximum.
- ATTACK, on adv: gain = min(gain+attack_step, GAIN_MAX), with step 0 giving GAIN_MAX directly. When gain reaches GAIN_MAX → DECAY.
- DECAY, on adv: gain = max(gain-decay_step, sustain_level), with step 0 giving sustain_level directly. When gain equals sustain_level → SUSTAIN. If sustain_level=GAIN_MAX, DECAY lasts one tick.
- SUSTAIN: gain tracks sustain_level every cycle.
- RELEASE, on adv: gain = max(gain-release_step, 0), with step 0 giving 0 directly. When gain reaches 0 → IDLE.
- All gain arithmetic uses GAIN_W+1 bits, so no wraparound.
- Datapath: on sample_ready && play_enable, the next cycle gives:
  - enabled: sample_out = (signed(sample_in) * {0,gain}) >>> GAIN_W, using an arithmetic (floor) shift and a SAMPLE_W+GAIN_W+1 bit product;
  - bypass (toggle_dynamics=0): sample_out = sample_in.
- sample_out_ready pulses for one cycle with latency 1. Otherwise sample_out holds its value.
- toggle_dynamics=0 does not stop the FSM; it bypasses only the datapath.

Decomposition:
- Package adsr_pkg holds the state encodings (ST_IDLE..ST_RELEASE) and the BEATS_TO_MINIBEATS=4 shift constant.
- Sub-module env_gain_scaler: a combinational signed×unsigned multiply plus shift, parametrised by SAMPLE_W/GAIN_W. It is reused by the future mixer.
- Registers use the existing dffr/dffre flops.

Test Plan:
- Attack/decay/sustain with defaults: attack_step=64, decay_step=32, sustain=128, duration=0. Gain after successive ticks is 64,128,192,255, then 223,191,159,128. State sequence is ATTACK→DECAY→SUSTAIN. A note_off then with release_step=64 gives 64,0, then IDLE, and busy drops.
- Scaling: gain=128 with sample_in=16'sd1000 gives 500; sample_in=-16'sd1 gives -1; gain=255 with 16'sh7FFF gives 16'sh7F7F. sample_out_ready rises exactly 1 cycle after sample_ready.
- Auto-release: duration=2 with all steps 0. The FSM goes to SUSTAIN after 2 ticks and enters RELEASE on tick 8 (counter=8). With release_step=0, gain is 0 and the state is IDLE one tick later.
- Retrigger: note_on during RELEASE at gain=100 with attack_step=50 returns to ATTACK, and gain goes 150 on the next tick (not 50). note_on and note_off in the same cycle → ATTACK.
- Freeze/bypass: play_enable=0 for 10 ticks leaves gain, state and sample_out unchanged. toggle_dynamics=0 gives sample_out=sample_in while env_gain keeps advancing.
- Reset mid-DECAY gives state=IDLE, gain=0, sample_out=0 on the next cycle.

Source files
------------

// File: rtl/adsr_pkg.sv
// Shared ADSR envelope encodings and constants.
package adsr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  localparam int BEATS_TO_MINIBEATS = 4;

endpackage

// File: rtl/env_gain_scaler.sv
// Combinational signed sample x unsigned gain, floor-shifted back to sample width.
module env_gain_scaler #(
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 8
) (
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic        [GAIN_W-1:0]   gain,
  output logic signed [SAMPLE_W-1:0] scaled
);

  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

  logic signed [PROD_W-1:0] sample_x;
  logic signed [PROD_W-1:0] gain_x;
  logic signed [PROD_W-1:0] product;
  logic                     unused_bits;

  assign sample_x = {{(GAIN_W+1){sample[SAMPLE_W-1]}}, sample};
  assign gain_x   = {{SAMPLE_W{1'b0}}, 1'b0, gain};
  assign product  = sample_x * gain_x;

  // |gain| < 2^GAIN_W, so the floor-shifted product always fits in SAMPLE_W bits.
  assign scaled      = product[GAIN_W +: SAMPLE_W];
  assign unused_bits = ^{product[PROD_W-1 -: 1], product[GAIN_W-1:0]};

endmodule

// File: rtl/adsr_envelope_gen.sv
// Linear ADSR gain envelope stepped on the minibeat tick, applied to a signed PCM stream.
// Output sample is registered one cycle after sample_ready; play_enable low freezes everything.
module adsr_envelope_gen
  import adsr_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 8,
  parameter int DUR_W    = 6,
  parameter int CNT_W    = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play_enable,
  input  logic                       toggle_dynamics,
  input  logic                       minibeat,
  input  logic                       note_on,
  input  logic                       note_off,
  input  logic        [DUR_W-1:0]    duration,
  input  logic        [GAIN_W-1:0]   attack_step,
  input  logic        [GAIN_W-1:0]   decay_step,
  input  logic        [GAIN_W-1:0]   sustain_level,
  input  logic        [GAIN_W-1:0]   release_step,
  input  logic                       sample_ready,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  output logic                       sample_out_ready,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic        [GAIN_W-1:0]   env_gain,
  output logic        [2:0]          env_state,
  output logic                       busy
);

  localparam logic [GAIN_W-1:0] GAIN_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  env_state_t          state_q, state_d;
  logic [GAIN_W-1:0]   gain_q, gain_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                adv;
  logic                in_note;
  logic                auto_rel;
  logic [CNT_W-1:0]    rel_cnt;
  logic [GAIN_W:0]     gain_x, atk_sum, dec_diff, rel_diff;
  logic [GAIN_W-1:0]   atk_gain, dec_gain, rel_gain;
  logic signed [SAMPLE_W-1:0] scaled;

  assign adv     = minibeat && play_enable;
  assign busy    = (state_q != ST_IDLE);
  assign in_note = (state_q == ST_ATTACK) || (state_q == ST_DECAY) || (state_q == ST_SUSTAIN);

  assign rel_cnt  = CNT_W'(duration) * CNT_W'(BEATS_TO_MINIBEATS);
  assign auto_rel = (duration != '0) && (cnt_q >= rel_cnt);

  // One extra bit keeps add/subtract from wrapping; the top bit flags overflow/underflow.
  assign gain_x   = {1'b0, gain_q};
  assign atk_sum  = gain_x + {1'b0, attack_step};
  assign dec_diff = gain_x - {1'b0, decay_step};
  assign rel_diff = gain_x - {1'b0, release_step};

  assign atk_gain = (attack_step == '0 || atk_sum >= {1'b0, GAIN_MAX}) ? GAIN_MAX
                                                                       : atk_sum[GAIN_W-1:0];
  assign dec_gain = (decay_step == '0 || dec_diff[GAIN_W] || dec_diff[GAIN_W-1:0] < sustain_level)
                    ? sustain_level : dec_diff[GAIN_W-1:0];
  assign rel_gain = (release_step == '0 || rel_diff[GAIN_W]) ? '0 : rel_diff[GAIN_W-1:0];

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    cnt_d   = cnt_q;
    if (play_enable) begin
      if (adv && busy && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      case (state_q)
        ST_IDLE: ;
        ST_ATTACK: if (adv) begin
          gain_d = atk_gain;
          if (atk_gain == GAIN_MAX) state_d = ST_DECAY;
        end
        ST_DECAY: if (adv) begin
          gain_d = dec_gain;
          if (dec_gain == sustain_level) state_d = ST_SUSTAIN;
        end
        ST_SUSTAIN: gain_d = sustain_level;
        ST_RELEASE: if (adv) begin
          gain_d = rel_gain;
          if (rel_gain == '0) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (in_note && (note_off || auto_rel)) state_d = ST_RELEASE;
      // Retrigger keeps the current gain so legato notes do not click.
      if (note_on) begin
        state_d = ST_ATTACK;
        gain_d  = gain_q;
        cnt_d   = '0;
      end
    end else if (state_q > ST_RELEASE) begin
      state_d = ST_IDLE;
    end
  end

  env_gain_scaler #(
    .SAMPLE_W (SAMPLE_W),
    .GAIN_W   (GAIN_W)
  ) u_scaler (
    .sample (sample_in),
    .gain   (gain_q),
    .scaled (scaled)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      gain_q           <= '0;
      cnt_q            <= '0;
      sample_out       <= '0;
      sample_out_ready <= 1'b0;
    end else begin
      state_q          <= state_d;
      gain_q           <= gain_d;
      cnt_q            <= cnt_d;
      sample_out_ready <= sample_ready && play_enable;
      if (sample_ready && play_enable)
        sample_out <= toggle_dynamics ? scaled : sample_in;
    end
  end

  assign env_gain  = gain_q;
  assign env_state = state_q;

endmodule

// File: tb/tb_adsr_envelope_gen.sv
// Directed bench for adsr_envelope_gen: table-driven envelope and scaling vectors plus corner sequences.
module tb_adsr_envelope_gen;

  logic              clk = 1'b0;
  logic              reset;
  logic              play_enable;
  logic              toggle_dynamics;
  logic              minibeat;
  logic              note_on;
  logic              note_off;
  logic [5:0]        duration;
  logic [7:0]        attack_step;
  logic [7:0]        decay_step;
  logic [7:0]        sustain_level;
  logic [7:0]        release_step;
  logic              sample_ready;
  logic signed [15:0] sample_in;
  logic              sample_out_ready;
  logic signed [15:0] sample_out;
  logic [7:0]        env_gain;
  logic [2:0]        env_state;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adsr_envelope_gen dut (
    .clk              (clk),
    .reset            (reset),
    .play_enable      (play_enable),
    .toggle_dynamics  (toggle_dynamics),
    .minibeat         (minibeat),
    .note_on          (note_on),
    .note_off         (note_off),
    .duration         (duration),
    .attack_step      (attack_step),
    .decay_step       (decay_step),
    .sustain_level    (sustain_level),
    .release_step     (release_step),
    .sample_ready     (sample_ready),
    .sample_in        (sample_in),
    .sample_out_ready (sample_out_ready),
    .sample_out       (sample_out),
    .env_gain         (env_gain),
    .env_state        (env_state),
    .busy             (busy)
  );

  typedef struct {
    bit on;
    bit off;
    bit mb;
    int gain;
    int st;
    bit bsy;
  } env_row_t;

  typedef struct {
    int sus;
    int smp;
    bit tog;
    int expv;
  } scale_row_t;

  env_row_t   env_tbl[12];
  scale_row_t scl_tbl[8];

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    minibeat = 1'b1;
    cyc();
    minibeat = 1'b0;
    cyc();
  endtask

  task automatic pulse_on();
    note_on = 1'b1;
    cyc();
    note_on = 1'b0;
  endtask

  task automatic pulse_off();
    note_off = 1'b1;
    cyc();
    note_off = 1'b0;
  endtask

  task automatic chk_env(input string name, input int g, input int s);
    chk({name, "_gain"}, int'(env_gain), g);
    chk({name, "_state"}, int'(env_state), s);
  endtask

  task automatic send_sample(input int smp);
    sample_in    = 16'(smp);
    sample_ready = 1'b1;
    cyc();
    sample_ready = 1'b0;
  endtask

  initial begin
    // ADSR with atk 64, dec 32, sus 128, rel 64
    env_tbl[0]  = '{1'b1, 1'b0, 1'b0,   0, 1, 1'b1};
    env_tbl[1]  = '{1'b0, 1'b0, 1'b1,  64, 1, 1'b1};
    env_tbl[2]  = '{1'b0, 1'b0, 1'b1, 128, 1, 1'b1};
    env_tbl[3]  = '{1'b0, 1'b0, 1'b1, 192, 1, 1'b1};
    env_tbl[4]  = '{1'b0, 1'b0, 1'b1, 255, 2, 1'b1};
    env_tbl[5]  = '{1'b0, 1'b0, 1'b1, 223, 2, 1'b1};
    env_tbl[6]  = '{1'b0, 1'b0, 1'b1, 191, 2, 1'b1};
    env_tbl[7]  = '{1'b0, 1'b0, 1'b1, 159, 2, 1'b1};
    env_tbl[8]  = '{1'b0, 1'b0, 1'b1, 128, 3, 1'b1};
    env_tbl[9]  = '{1'b0, 1'b1, 1'b0, 128, 4, 1'b1};
    env_tbl[10] = '{1'b0, 1'b0, 1'b1,  64, 4, 1'b1};
    env_tbl[11] = '{1'b0, 1'b0, 1'b1,   0, 0, 1'b0};

    scl_tbl[0] = '{128,   1000, 1'b1,    500};
    scl_tbl[1] = '{128,     -1, 1'b1,     -1};
    scl_tbl[2] = '{255,  32767, 1'b1,  32639};
    scl_tbl[3] = '{255, -32768, 1'b1, -32640};
    scl_tbl[4] = '{200,     -3, 1'b1,     -3};
    scl_tbl[5] = '{ 64,  -1000, 1'b1,   -250};
    scl_tbl[6] = '{  0,   1234, 1'b1,      0};
    scl_tbl[7] = '{200,    -77, 1'b0,    -77};

    reset = 1'b1; play_enable = 1'b1; toggle_dynamics = 1'b1;
    minibeat = 1'b0; note_on = 1'b0; note_off = 1'b0; duration = '0;
    attack_step = 8'd64; decay_step = 8'd32; sustain_level = 8'd128; release_step = 8'd64;
    sample_ready = 1'b0; sample_in = '0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    chk_env("rst", 0, 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out", int'(sample_out), 0);
    chk("rst_rdy", int'(sample_out_ready), 0);

    for (int i = 0; i < 12; i++) begin
      note_on  = env_tbl[i].on;
      note_off = env_tbl[i].off;
      minibeat = env_tbl[i].mb;
      cyc();
      note_on = 1'b0; note_off = 1'b0; minibeat = 1'b0;
      chk_env($sformatf("adsr%0d", i), env_tbl[i].gain, env_tbl[i].st);
      chk($sformatf("adsr%0d_busy", i), int'(busy), int'(env_tbl[i].bsy));
    end

    // reach SUSTAIN, then use sustain_level to dial the gain
    attack_step = '0; decay_step = '0;
    pulse_on(); tick(); tick();
    chk("scl_setup_state", int'(env_state), 3);
    for (int i = 0; i < 8; i++) begin
      sustain_level   = 8'(scl_tbl[i].sus);
      toggle_dynamics = scl_tbl[i].tog;
      cyc();
      send_sample(scl_tbl[i].smp);
      chk($sformatf("scl%0d_rdy", i), int'(sample_out_ready), 1);
      chk($sformatf("scl%0d_out", i), int'(sample_out), scl_tbl[i].expv);
      cyc();
      chk($sformatf("scl%0d_rdy_low", i), int'(sample_out_ready), 0);
      chk($sformatf("scl%0d_hold", i), int'(sample_out), scl_tbl[i].expv);
    end

    // freeze: ticks, note_off, samples and sustain change all ignored
    play_enable = 1'b0; sustain_level = 8'd50;
    sample_in = 16'sd999; sample_ready = 1'b1;
    note_off = 1'b1; cyc(); note_off = 1'b0;
    repeat (10) tick();
    chk_env("frz", 200, 3);
    chk("frz_out", int'(sample_out), -77);
    chk("frz_rdy", int'(sample_out_ready), 0);
    sample_ready = 1'b0; play_enable = 1'b1;
    cyc();
    chk("frz_resume_gain", int'(env_gain), 50);

    // bypass while the envelope keeps releasing
    release_step = 8'd10;
    pulse_off();
    tick();
    chk_env("byp_a", 40, 4);
    send_sample(1234);
    chk("byp_out", int'(sample_out), 1234);
    tick();
    chk_env("byp_b", 30, 4);

    // retrigger during RELEASE keeps gain
    pulse_on(); tick();
    sustain_level = 8'd200; tick();
    chk_env("rt_sus", 200, 3);
    release_step = 8'd100;
    pulse_off(); tick();
    chk_env("rt_rel", 100, 4);
    attack_step = 8'd50;
    pulse_on();
    chk_env("rt_on", 100, 1);
    tick();
    chk_env("rt_atk", 150, 1);
    attack_step = '0; tick();
    chk_env("rt_dec", 255, 2);
    note_on = 1'b1; note_off = 1'b1; cyc(); note_on = 1'b0; note_off = 1'b0;
    chk_env("rt_onoff", 255, 1);

    // reset in the middle of DECAY
    tick();
    decay_step = 8'd1; sustain_level = 8'd0; toggle_dynamics = 1'b1;
    tick();
    chk_env("rd_dec", 254, 2);
    send_sample(1000);
    chk("rd_out", int'(sample_out), 992);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk_env("rd", 0, 0);
    chk("rd_out0", int'(sample_out), 0);
    chk("rd_busy", int'(busy), 0);

    // auto-release after duration*4 minibeats
    duration = 6'd2; attack_step = '0; decay_step = '0; release_step = '0;
    sustain_level = 8'd128;
    pulse_on();
    tick(); tick();
    chk_env("ar_t2", 128, 3);
    repeat (5) tick();
    chk("ar_t7_state", int'(env_state), 3);
    tick();
    chk_env("ar_t8", 128, 4);
    tick();
    chk_env("ar_t9", 0, 0);
    chk("ar_busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
